sha256_digest_engine: RTL and testbench

- Parametrised SHA-256/SHA-224 compression engine. It runs 64 rounds over one 512-bit block, with a configurable number of rounds unrolled per clock.
- It chains multiple blocks: it holds the running H0..H7 and adds the working variables back at the end of each block.
- It sits between the message-schedule block, which supplies W words through a valid/ready handshake, and the top-level controller, which drives start/first_block and consumes the digest.
- The K constants and IVs are internal.

---
 rtl/sha256_pkg.sv | 103 ++++++++++
 rtl/sha256_digest_engine_round.sv | 24 ++
 rtl/sha256_digest_engine.sv | 120 ++++++++++++
 tb/tb_sha256_digest_engine.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// SHA-256/224 shared types, round constants, initial hash values
// and the FIPS 180-4 round helper functions.
package sha256_pkg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } sha_state_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } sha_fsm_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic sha_state_t iv_state(input logic m224);
    sha_state_t s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[255-32*i -: 32] = m224 ? IV224[i] : IV256[i];
    end
    return s;
  endfunction

  function automatic sha_state_t add_state(
    input sha_state_t x,
    input sha_state_t y
  );
    sha_state_t s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[255-32*i -: 32] = x[255-32*i -: 32] + y[255-32*i -: 32];
    end
    return s;
  endfunction

endpackage

// File: rtl/sha256_digest_engine_round.sv
// One combinational SHA-256 compression round.
// Chained RPC times by the engine to unroll rounds per clock.
module sha256_round
  import sha256_pkg::*;
(
  input  sha_state_t  cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output sha_state_t  nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = cur.h + bsig1(cur.e)
            + ch(cur.e, cur.f, cur.g) + k + w;
  assign t2 = bsig0(cur.a) + maj(cur.a, cur.b, cur.c);

  assign nxt = {
    t1 + t2, cur.a, cur.b, cur.c,
    cur.d + t1, cur.e, cur.f, cur.g
  };

endmodule

// File: rtl/sha256_digest_engine.sv
// SHA-256/224 block compression engine with RPC rounds per clock
// and multi-block chaining of H0..H7.
module sha256_digest_engine
  import sha256_pkg::*;
#(
  parameter int RPC   = 1,
  parameter int W_BUS = 32 * RPC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             first_block,
  input  logic             mode_224,
  input  logic [W_BUS-1:0] w_i,
  input  logic             w_valid,
  output logic             w_ready,
  output logic [5:0]       round_idx,
  output logic             busy,
  output logic             digest_valid,
  output logic [255:0]     hash_val
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
    $error("sha256_digest_engine: RPC must be 1, 2 or 4");
  end
  if (W_BUS != 32 * RPC) begin : g_bad_wbus
    $error("sha256_digest_engine: W_BUS must equal 32*RPC");
  end

  sha_fsm_t   state_q;
  sha_fsm_t   state_d;
  logic [5:0] cnt_q;
  sha_state_t work_q;
  sha_state_t h_q;
  logic       mode_q;
  logic       mode_pend_q;
  logic       use_iv_q;
  logic       dv_q;
  logic       last_grp;
  sha_state_t chain [RPC+1];

  assign last_grp = (cnt_q == 6'(64 - RPC));
  assign chain[0] = work_q;

  for (genvar i = 0; i < RPC; i++) begin : g_rnd
    sha256_round u_round (
      .cur (chain[i]),
      .k   (K[cnt_q + 6'(i)]),
      .w   (w_i[32*i +: 32]),
      .nxt (chain[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ROUND;
      ROUND:   if (w_valid && last_grp) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // H is committed only in FINAL so hash_val stays stable while
  // a new first block runs; IV and mode are applied at commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      work_q      <= '0;
      h_q         <= '0;
      mode_q      <= 1'b0;
      mode_pend_q <= 1'b0;
      use_iv_q    <= 1'b0;
      dv_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q    <= '0;
            dv_q     <= 1'b0;
            use_iv_q <= first_block;
            if (first_block) begin
              work_q      <= iv_state(mode_224);
              mode_pend_q <= mode_224;
            end else begin
              work_q      <= h_q;
              mode_pend_q <= mode_q;
            end
          end
        end
        ROUND: begin
          if (w_valid) begin
            work_q <= chain[RPC];
            cnt_q  <= cnt_q + 6'(RPC);
          end
        end
        FINAL: begin
          h_q <= add_state(
            use_iv_q ? iv_state(mode_pend_q) : h_q,
            work_q);
          mode_q <= mode_pend_q;
          dv_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_ready      = (state_q == ROUND);
  assign busy         = (state_q != IDLE);
  assign round_idx    = (state_q == ROUND) ? cnt_q : 6'd0;
  assign digest_valid = dv_q;
  assign hash_val     = {h_q[255:32], mode_q ? 32'h0 : h_q.h};

endmodule

// File: tb/tb_sha256_digest_engine.sv
// Directed bench for the SHA-256/224 engine at RPC 1, 2 and 4
// using known digests and a queue of expected results.
module tb_sha256_digest_engine;

  localparam logic [255:0] E_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] E_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] E_224 =
    256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

  logic clk = 1'b0;
  logic rst;
  logic start [3];
  logic first_block [3];
  logic mode_224 [3];
  logic w_valid [3];
  logic [127:0] w_bus [3];
  logic w_ready [3];
  logic busy [3];
  logic dv [3];
  logic [5:0] ridx [3];
  logic [255:0] hv [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int R = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    sha256_digest_engine #(.RPC(R)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start[g]),
      .first_block  (first_block[g]),
      .mode_224     (mode_224[g]),
      .w_i          (w_bus[g][32*R-1:0]),
      .w_valid      (w_valid[g]),
      .w_ready      (w_ready[g]),
      .round_idx    (ridx[g]),
      .busy         (busy[g]),
      .digest_valid (dv[g]),
      .hash_val     (hv[g])
    );
  end

  int passed = 0;
  int total = 0;
  logic [255:0] exp_q [$];
  logic [31:0] blk [16];
  logic [31:0] sched [64];

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic int rpc_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  task automatic expand();
    for (int t = 0; t < 16; t++) sched[t] = blk[t];
    for (int t = 16; t < 64; t++) begin
      sched[t] = (rr(sched[t-2], 17) ^ rr(sched[t-2], 19) ^ (sched[t-2] >> 10))
               + sched[t-7]
               + (rr(sched[t-15], 7) ^ rr(sched[t-15], 18) ^ (sched[t-15] >> 3))
               + sched[t-16];
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_two1();
    for (int i = 0; i < 14; i++)
      blk[i] = {8'(97 + i), 8'(98 + i), 8'(99 + i), 8'(100 + i)};
    blk[14] = 32'h80000000;
    blk[15] = 32'h0;
  endtask

  task automatic set_two2();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[15] = 32'h000001c0;
  endtask

  task automatic run_block(input int g, input bit first, input bit m224,
                           input bit stall, input bit pulse,
                           input bit has_exp, input logic [255:0] exp,
                           input int abort_at);
    int r;
    int idx;
    int guard;
    int cyc;
    bit v;
    logic [255:0] prev_h;
    logic [255:0] e;
    r = rpc_of(g);
    idx = 0;
    guard = 0;
    cyc = 0;
    expand();
    if (has_exp) exp_q.push_back(exp);
    prev_h = hv[g];
    @(negedge clk);
    start[g] = 1'b1;
    first_block[g] = first;
    mode_224[g] = m224;
    @(negedge clk);
    start[g] = 1'b0;
    chk("busy_after_start", busy[g], 1);
    chk("dv_cleared_on_start", dv[g], 0);
    chk("hash_stable_start", hv[g], prev_h);
    while (idx < 64 && guard < 2000) begin
      if (idx == abort_at) return;
      chk("round_idx", ridx[g], idx);
      chk("w_ready_round", w_ready[g], 1);
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      w_valid[g] = v;
      w_bus[g] = '0;
      for (int i = 0; i < r; i++) w_bus[g][32*i +: 32] = sched[idx + i];
      if (pulse && idx == 8) begin
        start[g] = 1'b1;
        first_block[g] = 1'b1;
        mode_224[g] = ~m224;
      end
      @(negedge clk);
      start[g] = 1'b0;
      guard++;
      cyc++;
      if (v) idx += r;
    end
    w_valid[g] = 1'b0;
    chk("round_budget", guard < 2000, 1);
    chk("final_w_ready", w_ready[g], 0);
    chk("final_busy", busy[g], 1);
    chk("final_no_dv", dv[g], 0);
    chk("hash_stable_final", hv[g], prev_h);
    if (pulse) start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    cyc++;
    chk("dv_set", dv[g], 1);
    chk("idle_not_busy", busy[g], 0);
    if (!stall) chk("latency", cyc, 64 / r + 1);
    if (has_exp && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("digest", hv[g], e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      first_block[g] = 1'b0;
      mode_224[g] = 1'b0;
      w_valid[g] = 1'b0;
      w_bus[g] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk("rst_busy", busy[g], 0);
      chk("rst_w_ready", w_ready[g], 0);
      chk("rst_dv", dv[g], 0);
      chk("rst_round_idx", ridx[g], 0);
      chk("rst_hash", hv[g], 0);
    end

    set_abc();
    run_block(0, 1, 0, 0, 0, 1, E_ABC, -1);

    set_two1();
    run_block(2, 1, 0, 0, 0, 0, '0, -1);
    set_two2();
    run_block(2, 0, 0, 0, 0, 1, E_TWO, -1);

    set_abc();
    run_block(1, 1, 1, 0, 0, 1, E_224, -1);
    chk("sha224_low_word", hv[1][31:0], 0);

    set_abc();
    run_block(0, 1, 0, 1, 0, 1, E_ABC, -1);

    set_abc();
    run_block(0, 1, 0, 0, 1, 1, E_ABC, -1);
    chk("ignored_start_final", busy[0], 0);

    set_abc();
    run_block(0, 0, 0, 0, 0, 0, '0, 30);
    w_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy[0], 0);
    chk("abort_w_ready", w_ready[0], 0);
    chk("abort_dv", dv[0], 0);
    chk("abort_round_idx", ridx[0], 0);
    chk("abort_hash", hv[0], 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_dv", dv[0], 0);

    set_abc();
    run_block(0, 1, 0, 0, 0, 1, E_ABC, -1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
